// File: rtl/instr_issue_if.sv
//------------------------------------------------------------------------------
// instr_issue_if : job handshake and instruction-buffer write bus
//   for instr_issue. Carries stall_cycles when ISSUE_STATS_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface instr_issue_if #(
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 8
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic               job_valid;
  logic               job_ready;
  logic [CNT_W-1:0]   job_tiles;
  logic               rd_nxt_inst;
  logic               wr_en;
  logic [INSTR_W-1:0] instr;
  logic               job_done;
  logic [OCC_W-1:0]   occupancy;
`ifdef ISSUE_STATS_EN
  logic [15:0]        stall_cycles;
`endif

`ifdef ISSUE_STATS_EN
  modport slave (
    input  job_valid, job_tiles, rd_nxt_inst,
    output job_ready, wr_en, instr, job_done, occupancy, stall_cycles
  );
  modport master (
    output job_valid, job_tiles, rd_nxt_inst,
    input  job_ready, wr_en, instr, job_done, occupancy, stall_cycles
  );
`else
  modport slave (
    input  job_valid, job_tiles, rd_nxt_inst,
    output job_ready, wr_en, instr, job_done, occupancy
  );
  modport master (
    output job_valid, job_tiles, rd_nxt_inst,
    input  job_ready, wr_en, instr, job_done, occupancy
  );
`endif

endinterface : instr_issue_if

`default_nettype wire

// File: rtl/instr_issue.sv
//------------------------------------------------------------------------------
// instr_issue : expands a tile-count job into one buffer write per tile,
//   gated by a credit counter. Optional macro ISSUE_STATS_EN adds stall_cycles.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_issue #(
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  instr_issue_if.slave  bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int FLD_W = INSTR_W - 2;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   tiles_q, idx_q;
  logic [OCC_W-1:0]   occ_q;
  logic               job_ready_q, wr_en_q, job_done_q;
  logic [INSTR_W-1:0] instr_q;

  logic               w_accept, w_issue, w_stall, w_dec, w_last, w_first;
  logic [FLD_W-1:0]   w_idx_fld;

  // Tile index field wraps modulo 2^(INSTR_W-2), or is zero-extended if wider.
  generate
    if (FLD_W <= CNT_W) begin : g_idx_trunc
      assign w_idx_fld = idx_q[FLD_W-1:0];
    end else begin : g_idx_ext
      assign w_idx_fld = {{(FLD_W-CNT_W){1'b0}}, idx_q};
    end
  endgenerate

  assign w_last  = (idx_q == tiles_q - CNT_W'(1));
  assign w_first = (idx_q == '0);
  assign w_dec   = bus.rd_nxt_inst && (occ_q != '0);

  always_comb begin
    state_d  = state_q;
    w_accept = 1'b0;
    w_issue  = 1'b0;
    w_stall  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.job_valid && job_ready_q) begin
          w_accept = 1'b1;
          state_d  = (bus.job_tiles == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (occ_q != OCC_FULL) begin
          w_issue = 1'b1;
          if (w_last) state_d = ST_DONE;
        end else begin
          w_stall = 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tiles_q     <= '0;
      idx_q       <= '0;
      occ_q       <= '0;
      job_ready_q <= 1'b0;
      wr_en_q     <= 1'b0;
      instr_q     <= '0;
      job_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      // Ready only after a full idle cycle, so a new job never shares job_done's cycle.
      job_ready_q <= (state_q == ST_IDLE) && !w_accept;
      wr_en_q     <= w_issue;
      job_done_q  <= (state_q == ST_DONE);
      if (w_accept) begin
        tiles_q <= bus.job_tiles;
        idx_q   <= '0;
      end else if (w_issue) begin
        idx_q <= idx_q + CNT_W'(1);
      end
      if (w_issue) instr_q <= {w_idx_fld, w_last, w_first};
      if (w_issue && !w_dec)      occ_q <= occ_q + OCC_W'(1);
      else if (!w_issue && w_dec) occ_q <= occ_q - OCC_W'(1);
    end
  end

  assign bus.job_ready = job_ready_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.instr     = instr_q;
  assign bus.job_done  = job_done_q;
  assign bus.occupancy = occ_q;

`ifdef ISSUE_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           stall_q <= '0;
    else if (w_accept)                  stall_q <= '0;
    else if (w_stall && stall_q != '1)  stall_q <= stall_q + 16'd1;
  end

  assign bus.stall_cycles = stall_q;
`else
  logic w_stall_unused;
  assign w_stall_unused = w_stall;
`endif

endmodule : instr_issue

`default_nettype wire
